reg_file_storage: RTL
=====================

Name: reg_file_storage

Overview:
- 32 x 64-bit architectural register array with a single write port.
- Drives the full register bank to the downstream read-port selector, which implements two 5-bit-addressed 64-bit read ports.
- Writes pass through a one-entry staging register and commit one cycle later.
- The staged write is exposed so the read stage or the forwarding logic can bypass it.
- Register 31 is the hardwired zero register.

Parameters:
- NREG, 32, number of architectural registers (fixed at 32; address width 5).
- WIDTH, 64, register data width in bits.
- ZERO_REG, 31, index of the register that always reads 0 and ignores writes.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- RegWrite  input  1  write request qualifier, sampled on the rising edge of clk.
- WriteRegister  input  5  destination register index.
- WriteData  input  64  data to write.
- regs  output  [31:0][63:0]  committed register contents; regs[i] = register i; feeds the read-port selector.
- pendValid  output  1  a staged write is awaiting commit.
- pendReg  output  5  index of the staged write.
- pendData  output  64  data of the staged write.

Behaviour:
- Reset (asynchronous, active-high; takes effect regardless of clk):
  - all 32 registers = 0
  - pendValid = 0, pendReg = 0, pendData = 0
  - a staged write in progress when reset asserts is discarded, never committed.
  - Outputs hold these values for as long as reset is high.
- Stage 1, capture. On each rising clk with reset low:
  - pendValid <= RegWrite && (WriteRegister != ZERO_REG)
  - pendReg <= WriteRegister and pendData <= WriteData when that condition is true.
  - Otherwise pendReg and pendData hold their previous values.
- Stage 2, commit. On the same edge, if pendValid was 1 before the edge, register[pendReg] <= pendData. Commit uses the pre-edge pending values, so capture and commit happen together every cycle.
- Write latency:
  - request sampled at edge N;
  - visible on pendValid/pendReg/pendData after edge N;
  - visible on regs after edge N+1.
- Back-to-back writes: one write per cycle is sustained. No stall, no busy signal, no request is dropped.
- Same register written on consecutive cycles: commits occur in order; the later data wins after its own commit edge.
- Zero register:
  - regs[ZERO_REG] is constant 0 at all times, including after reset.
  - A write to ZERO_REG is never staged (pendValid stays 0) and never committed.
- Write decode: the 5-bit index is decoded to 32 one-hot enables. Exactly one register updates per commit; all others hold.
- Forwarding contract:
  - regs never reflects the staged entry.
  - A consumer that needs the newest value of register r uses pendData when pendValid && pendReg == r, and regs[r] otherwise.
- No other state exists. There is no read addressing in this block; read selection belongs to the downstream selector.
- X/Z on WriteRegister or WriteData while RegWrite = 0 must not affect state.

Test Plan:
- Reset: assert reset mid-cycle with pendValid = 1 (write X5 = 0xAAAA staged).
  - Required: regs all 0 and pendValid = 0 immediately, without waiting for a clock edge.
  - Required: X5 still 0 after reset releases and 2 more edges.
- Basic write: RegWrite = 1, WriteRegister = 3, WriteData = 0x0123456789ABCDEF at edge 1.
  - Required after edge 1: pendValid = 1, pendReg = 3, pendData = 0x0123456789ABCDEF, regs[3] = 0.
  - Required after edge 2: regs[3] = 0x0123456789ABCDEF and pendValid = 0.
- Back-to-back: write X1 = 1, X2 = 2, X1 = 3 on edges 1-3, then RegWrite = 0.
  - Required after edge 2: regs[1] = 1.
  - Required after edge 3: regs[2] = 2.
  - Required after edge 4: regs[1] = 3.
  - Required: no other register changes at any point.
- Zero register: write X31 = 0xFFFFFFFFFFFFFFFF.
  - Required: pendValid stays 0 and regs[31] = 0 on every cycle.
  - Required: all 32 entries unchanged.
- Sweep: write register i = i * 0x0101010101010101 for i = 0..30 on consecutive cycles.
  - Required: one cycle after the last write, every regs[i] matches.
  - Required: regs[31] = 0.
- Idle hold: RegWrite = 0 with random WriteRegister/WriteData for 100 cycles.
  - Required: regs unchanged and pendValid = 0 throughout.

Source files
------------

// File: rtl/reg_file_storage.sv
// -----------------------------------------------------------------------------
// reg_file_storage
//
// Architectural register bank: NREG x WIDTH registers behind a single write
// port. A write request is first captured into a one-entry staging register
// and committed into the bank on the following clock edge. The staged entry
// is exported so the read stage / forwarding logic can bypass it. The full
// committed bank is driven out to the downstream read-port selector; there is
// no read addressing in this block. Register ZERO_REG is hardwired to zero.
//
// Ports
//   clk            in   system clock, rising-edge
//   reset          in   asynchronous, active-high; clears all state
//   RegWrite       in   write request qualifier
//   WriteRegister  in   destination register index
//   WriteData      in   data to write
//   regs           out  committed register contents, regs[i] = register i
//   pendValid      out  a staged write is awaiting commit
//   pendReg        out  index of the staged write
//   pendData       out  data of the staged write
// -----------------------------------------------------------------------------
module reg_file_storage #(
  parameter int NREG     = 32,
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             RegWrite,
  input  logic [$clog2(NREG)-1:0]          WriteRegister,
  input  logic [WIDTH-1:0]                 WriteData,
  output logic [NREG-1:0][WIDTH-1:0]       regs,
  output logic                             pendValid,
  output logic [$clog2(NREG)-1:0]          pendReg,
  output logic [WIDTH-1:0]                 pendData
);

  localparam int AW = $clog2(NREG);

  // ---------------------------------------------------------------------------
  // Stage 1: capture into the staging register
  // ---------------------------------------------------------------------------
  logic             pend_valid_q, pend_valid_d;
  logic [AW-1:0]    pend_reg_q,   pend_reg_d;
  logic [WIDTH-1:0] pend_data_q,  pend_data_d;
  logic             capture;

  // NOTE: every signal written here gets a value on every path (defaults
  // first), otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    capture     = RegWrite && (WriteRegister != AW'(ZERO_REG));
    pend_valid_d = capture;
    pend_reg_d   = pend_reg_q;
    pend_data_d  = pend_data_q;
    if (capture) begin
      pend_reg_d  = WriteRegister;
      pend_data_d = WriteData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values; this is what lets commit use the old staged entry while
  // capture loads the new one on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_reg_q   <= '0;
      pend_data_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_reg_q   <= pend_reg_d;
      pend_data_q  <= pend_data_d;
    end
  end

  assign pendValid = pend_valid_q;
  assign pendReg   = pend_reg_q;
  assign pendData  = pend_data_q;

  // ---------------------------------------------------------------------------
  // Stage 2: commit the staged entry into the bank
  // ---------------------------------------------------------------------------
  // Each register decodes its own one-hot enable from the pre-edge staged
  // index. The zero register has no storage at all, so it cannot be written
  // even if a stray index ever reached the staging register.
  logic [WIDTH-1:0] reg_val [NREG];

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    if (g == ZERO_REG) begin : g_zero
      assign reg_val[g] = '0;
    end else begin : g_flop
      logic             wr_en;
      logic [WIDTH-1:0] data_q;

      assign wr_en = pend_valid_q && (pend_reg_q == AW'(g));

      // NOTE: the bank is a flop array, not a RAM macro, and architectural
      // state must read zero out of reset, so each entry is reset here.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q <= '0;
        end else if (wr_en) begin
          data_q <= pend_data_q;
        end
      end

      assign reg_val[g] = data_q;
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 0; i < NREG; i++) begin
      regs[i] = reg_val[i];
    end
  end

endmodule
